bool_debounce_stage: RTL

Upstream producer stage for `p::bool_t` consumers. Filters a raw 1-bit input into a debounced `p::bool_t` level and emits one handshaked event per debounced transition. Downstream consumers that `import p::*` and assign from `TRUE`/`FALSE` take `level` or the event stream directly. The block itself uses explicit literal imports (`import p::bool_t; import p::TRUE; import p::FALSE;`), so it exercises LRM 26.3 enum literal visibility in sequential RTL.

---
 rtl/bool_debounce_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bool_debounce_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bool_debounce_stage: debounces a raw bit into a p::bool_t level and        |
// | emits one valid/ready event per debounced transition. Rev 1.0             |
// +----------------------------------------------------------------------------+

package p;
  typedef enum logic {FALSE = 1'b0, TRUE = 1'b1} bool_t;
endpackage

module bool_debounce_stage
  import p::bool_t;
  import p::TRUE;
  import p::FALSE;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_raw,
  output bool_t level,
  output logic  out_valid,
  output bool_t out_val,
  input  logic  out_ready,
  output logic  overrun
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_PEND_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_PEND_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_event;
  bool_t            w_new_level;
  bool_t            r_level;
  logic             r_out_valid;
  bool_t            r_out_val;
  logic             r_overrun;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A sample matching the current level always aborts a pending change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_event     = 1'b0;
    w_new_level = FALSE;
    case (r_state)
      S_LOW: begin
        w_cnt_nxt = '0;
        if (in_raw) begin
          if (STABLE_CYCLES == 1) begin
            w_state_nxt = S_HIGH;
            w_event     = 1'b1;
            w_new_level = TRUE;
          end else begin
            w_state_nxt = S_PEND_HIGH;
            w_cnt_nxt   = c_cnt_one;
          end
        end
      end
      S_PEND_HIGH: begin
        if (!in_raw) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
          w_event     = 1'b1;
          w_new_level = TRUE;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      S_HIGH: begin
        w_cnt_nxt = '0;
        if (!in_raw) begin
          if (STABLE_CYCLES == 1) begin
            w_state_nxt = S_LOW;
            w_event     = 1'b1;
            w_new_level = FALSE;
          end else begin
            w_state_nxt = S_PEND_LOW;
            w_cnt_nxt   = c_cnt_one;
          end
        end
      end
      S_PEND_LOW: begin
        if (in_raw) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
          w_event     = 1'b1;
          w_new_level = FALSE;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A new event replaces a pending one only when that one is consumed this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level     <= FALSE;
      r_out_valid <= 1'b0;
      r_out_val   <= FALSE;
      r_overrun   <= 1'b0;
    end else begin
      if (w_event) begin
        r_level <= w_new_level;
      end
      if (w_event && (!r_out_valid || out_ready)) begin
        r_out_valid <= 1'b1;
        r_out_val   <= w_new_level;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_event && r_out_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign level     = r_level;
  assign out_valid = r_out_valid;
  assign out_val   = r_out_val;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire
